sum_game_engine: RTL
====================

// Module: sum_game_engine
// PURPOSE
//  Parametrised "pick-to-target" game engine: computer and human alternately claim distinct numbers 1..MAX_NUM.
//  The first player whose set holds three numbers summing to TARGET wins.
//  Generalises the fixed 1..9/15 game FSM: adds width/target parameters, illegal-move flag, draw detection and a computed strategy.
//  Sits between switch/button synchronisers and the seven-segment display drivers.
// PARAMETERS
//  MAX_NUM     9   highest claimable number; W = $clog2(MAX_NUM+1) (localparam)
//  TARGET      15  winning triple sum; must satisfy 6 <= TARGET <= 3*MAX_NUM-3
//  SLOTS       5   display slots per player; must be >= ceil(MAX_NUM/2)
//  FIRST_MOVE  5   computer's opening number, 1..MAX_NUM
// PORTS
//  clock      in   1        system clock; all state updates on posedge
//  reset_L    in   1        synchronous reset, active low
//  hMove      in   W        human's candidate number
//  enter_L    in   1        submit button, active low, already synchronised
//  newGame_L  in   1        restart, active low, synchronous
//  cMove      out  W        computer's most recent move; 0 = none
//  hSlots     out  SLOTS*W  human numbers, ascending from slot 0, unused slots = 0
//  cSlots     out  SLOTS*W  computer numbers, same format
//  hWin       out  1        human has won
//  cWin       out  1        computer has won
//  draw       out  1        all numbers claimed, nobody won
//  illegal    out  1        last submitted hMove was rejected
// BEHAVIOUR
//  - Reset (reset_L=0 at posedge): sets cleared, cMove=0, hWin=cWin=draw=illegal=0, enterPrev=1, state<=C_TURN.
//    All slots therefore read 0.
//  - newGame_L=0 at posedge: same effect as reset. Priority is reset_L > newGame_L > enter_L.
//  - Internal state: bitmaps hSet/cSet[MAX_NUM:1]; state is one of C_TURN, H_WAIT, H_WON, C_WON, DRAW.
//  - Press: press = ~enter_L & enterPrev, with enterPrev <= enter_L every cycle.
//    Holding enter_L low yields exactly one press.
//    A press in any state other than H_WAIT is discarded.
//  - C_TURN (one cycle): the choice is set in cSet and cMove <= choice.
//    Next state, first match: cWin -> C_WON; no free number left -> DRAW; otherwise H_WAIT.
//  - Choice order:
//    (1) FIRST_MOVE if cSet is empty and FIRST_MOVE is free;
//    (2) the lowest free x completing a cSet pair a<b with a+b+x == TARGET;
//    (3) the lowest free x completing an hSet pair the same way (block);
//    (4) the lowest free number.
//  - H_WAIT + press, illegal move (hMove==0, hMove>MAX_NUM, or already claimed):
//    illegal <= 1; state and sets unchanged.
//  - H_WAIT + press, legal move: hSet gains hMove and illegal <= 0.
//    Next state: hWin -> H_WON; all numbers claimed -> DRAW; otherwise C_TURN.
//    The computer reply is visible on cMove 2 posedges after the accepted press.
//  - H_WON/C_WON/DRAW are absorbing until newGame_L or reset_L. hWin/cWin/draw are registered with the state and held.
//  - Triple detection runs combinationally on the set bitmaps (unordered, distinct a<b<c). Sums are computed at W+2 bits, with no overflow.
//  - Slot outputs are a combinational ascending extraction of the bitmaps, so they change in the cycle after the claim.
// CONFIGURATION
//  - SUMGAME_HUMAN_FIRST_EN defined: reset/newGame enter H_WAIT instead of C_TURN. The computer never makes an opening move, so rule (1) is unused. C_TURN follows each legal human move as usual.
//  - Not defined: the computer opens with FIRST_MOVE as specified above.
// STRUCTURE
//  - Package sum_game_pkg holds: the state_t enum (C_TURN, H_WAIT, H_WON, C_WON, DRAW) and the default-parameter constants.
//  - Sub-module sum_game_chooser (combinational) takes hSet, cSet and returns choice, cWinNext and noneFree.
//  - Sub-module sum_triple_detect is instantiated twice inside this block (hSet, cSet).
//  - The top level holds the FSM, edge detect, legality check and slot extraction.
// TESTING  (defaults: MAX_NUM=9, TARGET=15, FIRST_MOVE=5)
//  1. reset_L low 1 cycle, then high -> posedge 2: cMove=5, cSlots={5,0,0,0,0}, state H_WAIT, all flags 0.
//  2. hMove=6, enter_L low for 3 cycles -> one move only: hSlots={6,0..}, cMove=1 (rule 4), cSlots={1,5,0..}.
//  3. Continue from 2: hMove=5 press -> illegal=1, sets unchanged. hMove=9 press -> illegal=0, hSlots={6,9,..}, cMove=2.
//  4. Continue from 3: hMove=4 press -> computer completes 2+5+8: cMove=8, cWin=1, state C_WON.
//     A further press with hMove=3 leaves everything unchanged.
//  5. newGame_L low -> cMove=5. Human 9 -> cMove=1. Human 2 -> block: cMove=4 (rule 3), cWin=0.
//  6. newGame_L and enter_L both low on the same posedge in H_WAIT -> game restarts, the press is ignored and hSlots stay 0.
//     Repeat the bench with SUMGAME_HUMAN_FIRST_EN defined: after reset, cMove=0 until the first human move.

Source files
------------

// File: rtl/sum_game_pkg.sv
// ==== sum_game_pkg : shared state type and default game constants (rev 1.0) ====
`default_nettype none

package sum_game_pkg;

  typedef enum logic [2:0] {
    C_TURN = 3'd0,
    H_WAIT = 3'd1,
    H_WON  = 3'd2,
    C_WON  = 3'd3,
    DRAW   = 3'd4
  } state_t;

  localparam int DEF_MAX_NUM    = 9;
  localparam int DEF_TARGET     = 15;
  localparam int DEF_SLOTS      = 5;
  localparam int DEF_FIRST_MOVE = 5;

endpackage

`default_nettype wire

// File: rtl/sum_game_chooser.sv
// ==== sum_game_chooser : computer move selection (open, win, block, lowest free) (rev 1.0) ====
`default_nettype none

module sum_game_chooser
  import sum_game_pkg::*;
#(
  parameter  int MAX_NUM    = DEF_MAX_NUM,
  parameter  int TARGET     = DEF_TARGET,
  parameter  int FIRST_MOVE = DEF_FIRST_MOVE,
  localparam int W          = $clog2(MAX_NUM + 1)
) (
  input  logic [MAX_NUM:1] h_set,
  input  logic [MAX_NUM:1] c_set,
  output logic [W-1:0]     choice,
  output logic             c_win_next,
  output logic             none_free
);

  localparam int SW = W + 2;

  logic [MAX_NUM:1] free_bits;
  logic [MAX_NUM:1] c_comp;
  logic [MAX_NUM:1] h_comp;
  logic [MAX_NUM:1] choice_bits;
  logic [MAX_NUM:1] c_after;
  logic [W-1:0]     pick_c;
  logic [W-1:0]     pick_h;
  logic [W-1:0]     pick_f;
  logic             opening;

  assign free_bits = ~(h_set | c_set);

`ifdef SUMGAME_HUMAN_FIRST_EN
  assign opening = 1'b0;
`else
  assign opening = (c_set == '0) && free_bits[FIRST_MOVE];
`endif

  // x completes a pair when both partners already sit in one player's set
  always_comb begin
    c_comp = '0;
    h_comp = '0;
    for (int x = 1; x <= MAX_NUM; x++) begin
      for (int a = 1; a <= MAX_NUM; a++) begin
        for (int b = a + 1; b <= MAX_NUM; b++) begin
          if (free_bits[x] && (SW'(a) + SW'(b) + SW'(x) == SW'(TARGET))) begin
            if (c_set[a] && c_set[b]) c_comp[x] = 1'b1;
            if (h_set[a] && h_set[b]) h_comp[x] = 1'b1;
          end
        end
      end
    end
  end

  // descending scan so the lowest candidate is the one left standing
  always_comb begin
    pick_c = '0;
    pick_h = '0;
    pick_f = '0;
    for (int x = MAX_NUM; x >= 1; x--) begin
      if (c_comp[x])    pick_c = W'(x);
      if (h_comp[x])    pick_h = W'(x);
      if (free_bits[x]) pick_f = W'(x);
    end
  end

  always_comb begin
    if (opening)         choice = W'(FIRST_MOVE);
    else if (|c_comp)    choice = pick_c;
    else if (|h_comp)    choice = pick_h;
    else                 choice = pick_f;
  end

  always_comb begin
    choice_bits = '0;
    for (int x = 1; x <= MAX_NUM; x++)
      if (choice == W'(x)) choice_bits[x] = 1'b1;
  end

  assign c_after   = c_set | choice_bits;
  assign none_free = &(h_set | c_after);

  sum_triple_detect #(
    .MAX_NUM (MAX_NUM),
    .TARGET  (TARGET)
  ) u_c_detect (
    .bits  (c_after),
    .found (c_win_next)
  );

endmodule

`default_nettype wire

// File: rtl/sum_triple_detect.sv
// ==== sum_triple_detect : flags any three distinct members of a bitmap summing to TARGET (rev 1.0) ====
`default_nettype none

module sum_triple_detect
  import sum_game_pkg::*;
#(
  parameter  int MAX_NUM = DEF_MAX_NUM,
  parameter  int TARGET  = DEF_TARGET,
  localparam int W       = $clog2(MAX_NUM + 1)
) (
  input  logic [MAX_NUM:1] bits,
  output logic             found
);

  localparam int SW = W + 2;

  always_comb begin
    found = 1'b0;
    for (int a = 1; a <= MAX_NUM; a++) begin
      for (int b = a + 1; b <= MAX_NUM; b++) begin
        for (int c = b + 1; c <= MAX_NUM; c++) begin
          if (bits[a] && bits[b] && bits[c] &&
              (SW'(a) + SW'(b) + SW'(c) == SW'(TARGET)))
            found = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sum_game_engine.sv
// ==== sum_game_engine : pick-to-target game FSM, legality, slot display; SUMGAME_HUMAN_FIRST_EN lets the human open (rev 1.0) ====
`default_nettype none

module sum_game_engine
  import sum_game_pkg::*;
#(
  parameter  int MAX_NUM    = DEF_MAX_NUM,
  parameter  int TARGET     = DEF_TARGET,
  parameter  int SLOTS      = DEF_SLOTS,
  parameter  int FIRST_MOVE = DEF_FIRST_MOVE,
  localparam int W          = $clog2(MAX_NUM + 1)
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic [W-1:0]       hMove,
  input  logic               enter_L,
  input  logic               newGame_L,
  output logic [W-1:0]       cMove,
  output logic [SLOTS*W-1:0] hSlots,
  output logic [SLOTS*W-1:0] cSlots,
  output logic               hWin,
  output logic               cWin,
  output logic               draw,
  output logic               illegal
);

`ifdef SUMGAME_HUMAN_FIRST_EN
  localparam state_t START_STATE = H_WAIT;
`else
  localparam state_t START_STATE = C_TURN;
`endif

  state_t           state, state_n;
  logic [MAX_NUM:1] h_set, c_set, h_set_n, c_set_n;
  logic [MAX_NUM:1] h_bit, c_bit, h_cand;
  logic [W-1:0]     cmove_n;
  logic [W-1:0]     choice;
  logic             illegal_n;
  logic             enter_prev;
  logic             press;
  logic             legal;
  logic             h_win_next;
  logic             c_win_next;
  logic             none_free;
  logic             h_all_claimed;

  assign press = ~enter_L & enter_prev;

  sum_game_chooser #(
    .MAX_NUM    (MAX_NUM),
    .TARGET     (TARGET),
    .FIRST_MOVE (FIRST_MOVE)
  ) u_chooser (
    .h_set      (h_set),
    .c_set      (c_set),
    .choice     (choice),
    .c_win_next (c_win_next),
    .none_free  (none_free)
  );

  // zero or out-of-range values decode to an empty bitmap and so are never legal
  always_comb begin
    h_bit = '0;
    c_bit = '0;
    for (int x = 1; x <= MAX_NUM; x++) begin
      if (hMove == W'(x))  h_bit[x] = 1'b1;
      if (choice == W'(x)) c_bit[x] = 1'b1;
    end
  end

  assign legal         = (|h_bit) && ((h_bit & (h_set | c_set)) == '0);
  assign h_cand        = h_set | h_bit;
  assign h_all_claimed = &(h_cand | c_set);

  sum_triple_detect #(
    .MAX_NUM (MAX_NUM),
    .TARGET  (TARGET)
  ) u_h_detect (
    .bits  (h_cand),
    .found (h_win_next)
  );

  always_ff @(posedge clock) begin
    if (!reset_L || !newGame_L) begin
      state      <= START_STATE;
      h_set      <= '0;
      c_set      <= '0;
      cMove      <= '0;
      illegal    <= 1'b0;
      hWin       <= 1'b0;
      cWin       <= 1'b0;
      draw       <= 1'b0;
      enter_prev <= 1'b1;
    end else begin
      state      <= state_n;
      h_set      <= h_set_n;
      c_set      <= c_set_n;
      cMove      <= cmove_n;
      illegal    <= illegal_n;
      hWin       <= (state_n == H_WON);
      cWin       <= (state_n == C_WON);
      draw       <= (state_n == DRAW);
      enter_prev <= enter_L;
    end
  end

  always_comb begin
    state_n   = state;
    h_set_n   = h_set;
    c_set_n   = c_set;
    cmove_n   = cMove;
    illegal_n = illegal;
    case (state)
      C_TURN: begin
        c_set_n = c_set | c_bit;
        cmove_n = choice;
        if (c_win_next)     state_n = C_WON;
        else if (none_free) state_n = DRAW;
        else                state_n = H_WAIT;
      end
      H_WAIT: begin
        if (press) begin
          if (legal) begin
            h_set_n   = h_cand;
            illegal_n = 1'b0;
            if (h_win_next)         state_n = H_WON;
            else if (h_all_claimed) state_n = DRAW;
            else                    state_n = C_TURN;
          end else begin
            illegal_n = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // ascending slot packing; slot 0 holds the smallest claimed number
  always_comb begin
    int hk;
    int ck;
    hSlots = '0;
    cSlots = '0;
    hk = 0;
    ck = 0;
    for (int x = 1; x <= MAX_NUM; x++) begin
      if (h_set[x]) begin
        if (hk < SLOTS) hSlots[hk*W +: W] = W'(x);
        hk = hk + 1;
      end
      if (c_set[x]) begin
        if (ck < SLOTS) cSlots[ck*W +: W] = W'(x);
        ck = ck + 1;
      end
    end
  end

endmodule

`default_nettype wire
